// File: rtl/uart_pkg.sv
// Shared UART definitions.
// The default bit period is also used by the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic 1-bit two-flop synchroniser.
// RESET_VAL sets the value both flops take on reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling.
// Received bytes are held on a valid/ready output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST =
    CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_BITS - 1);

  rx_state_t state;
  rx_state_t state_n;

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
  logic                 sample;
  logic                 byte_done;
  logic                 stop_bad;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_comb begin
    state_n = state;
    sample  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          sample  = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          sample = 1'b1;
          if (idx == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          sample  = 1'b1;
          state_n = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_done = (state == STOP) && sample && rx_s;
  assign stop_bad  = (state == STOP) && sample && !rx_s;

  // cnt restarts on every state change and after every sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if (sample || (state_n != state)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (state == START) idx <= '0;
      if ((state == DATA) && sample) begin
        shreg[idx] <= rx_s;
        idx        <= idx + IW'(1);
      end
    end
  end

  // a full, undrained holding register drops the new byte
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && data_valid && !data_ready;
      if (byte_done && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with an ideal UART source.
// Bytes and flags are compared against bench-side expectations.
module tb_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int stab_err = 0;
  bit busy_seen = 1'b0;
  logic [7:0] rx_q[$];

  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic       p_rst = 1'b1;
  logic [7:0] p_data = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_hold;
    int         gap;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) rx_q.push_back(data_out);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (busy) busy_seen = 1'b1;
      if (!p_rst && p_valid && !p_ready &&
          (!data_valid || data_out != p_data))
        stab_err++;
    end
    p_rst   = rst;
    p_valid = data_valid;
    p_ready = data_ready;
    p_data  = data_out;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (C - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    @(posedge clk);
    #1 rx = 1'b0;
    fall_cyc = cyc;
    repeat (C - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int q0, f0, o0, lat, nexp, base;
    bit got;
    logic [7:0] seen, b;
    logic [7:0] exp_q[$];
    bit bad;
    int gap, exp_ferr;

    vecs[0] = '{8'h00, 1'b1, 0, 0, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 0, 0, 1, 0};
    vecs[2] = '{8'h80, 1'b1, 0, 3, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 40, 6, 0, 1};
    vecs[4] = '{8'h3C, 1'b1, 0, 2, 1, 0};
    vecs[5] = '{8'hA5, 1'b1, 0, 0, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst data_out", int'(data_out), 0);
    check("rst data_valid", int'(data_valid), 0);
    check("rst frame_err", int'(frame_err), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    data_ready = 1'b1;
    idle(5);

    // single byte, latency from falling edge
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    got = 1'b0;
    lat = 0;
    seen = 8'h00;
    fork
      send_frame(8'h42, 1'b1);
      begin
        for (int i = 0; i < 400 && !got; i++) begin
          @(negedge clk);
          if (data_valid) begin
            got = 1'b1;
            lat = cyc - fall_cyc;
            seen = data_out;
          end
        end
        check("t1 valid seen", int'(got), 1);
        check("t1 latency", lat, 2 + 8 + 9 * C + 1);
        check("t1 data", int'(seen), 8'h42);
        @(negedge clk);
        check("t1 valid pulse", int'(data_valid), 0);
      end
    join
    idle(4);
    check("t1 frame_err", ferr_cnt - f0, 0);
    check("t1 overrun", ovr_cnt - o0, 0);

    // back-to-back with consumer stalled
    data_ready = 1'b0;
    q0 = rx_q.size();
    o0 = ovr_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    idle(4);
    @(negedge clk);
    check("t2 valid held", int'(data_valid), 1);
    check("t2 data held", int'(data_out), 8'h55);
    check("t2 overrun", ovr_cnt - o0, 1);
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t2 valid drop", int'(data_valid), 0);
    check("t2 accepted", rx_q.size() - q0, 1);
    if (rx_q.size() > q0)
      check("t2 accepted data", int'(rx_q[q0]), 8'h55);
    idle(3);

    // table of single frames
    for (int v = 0; v < 6; v++) begin
      q0 = rx_q.size();
      f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      if (!vecs[v].stop) begin
        repeat (vecs[v].low_hold) @(posedge clk);
        @(posedge clk);
        #1 rx = 1'b1;
      end
      repeat (vecs[v].gap) @(posedge clk);
      check($sformatf("vec%0d bytes", v),
            rx_q.size() - q0, vecs[v].exp_bytes);
      if (rx_q.size() > q0)
        check($sformatf("vec%0d data", v),
              int'(rx_q[q0]), int'(vecs[v].data));
      check($sformatf("vec%0d frame_err", v),
            ferr_cnt - f0, vecs[v].exp_ferr);
    end
    idle(20);

    // short low glitch
    q0 = rx_q.size();
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    @(posedge clk);
    #1 rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    check("glitch busy seen", int'(busy_seen), 1);
    check("glitch busy idle", int'(busy), 0);
    check("glitch no byte", rx_q.size() - q0, 0);
    check("glitch no ferr", ferr_cnt - f0, 0);

    // randomized frames against the model
    base = rx_q.size();
    f0 = ferr_cnt;
    exp_ferr = 0;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      gap = $urandom_range(0, 12);
      if (bad) exp_ferr++;
      else exp_q.push_back(b);
      send_frame(b, !bad);
      if (bad) begin
        @(posedge clk);
        #1 rx = 1'b1;
        gap = gap + 3;
      end
      repeat (gap) @(posedge clk);
    end
    idle(20);
    nexp = exp_q.size();
    check("rand count", rx_q.size() - base, nexp);
    for (int i = 0; i < nexp; i++) begin
      if (base + i < rx_q.size())
        check($sformatf("rand byte%0d", i),
              int'(rx_q[base + i]), int'(exp_q[i]));
    end
    check("rand frame_err", ferr_cnt - f0, exp_ferr);

    // reset mid-frame with a byte held
    data_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    idle(4);
    @(negedge clk);
    check("rst pre valid", int'(data_valid), 1);
    b = 8'h99;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (C - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    send_bit(b[4]);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("mid rst data_out", int'(data_out), 0);
    check("mid rst valid", int'(data_valid), 0);
    check("mid rst busy", int'(busy), 0);
    check("mid rst flags",
          int'({frame_err, overrun}), 0);
    idle(12 * C);
    data_ready = 1'b1;
    q0 = rx_q.size();
    f0 = ferr_cnt;
    send_frame(8'h99, 1'b1);
    idle(10);
    check("post rst bytes", rx_q.size() - q0, 1);
    if (rx_q.size() > q0)
      check("post rst data", int'(rx_q[q0]), 8'h99);
    check("post rst ferr", ferr_cnt - f0, 0);

    check("held data stable", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the consumer of the serial line driven by the team's UART transmitter.
- Synchronises the asynchronous rx line, detects the start bit and samples each bit at mid-bit.
- Presents each received byte on a valid/ready output interface.
- Flags framing errors and overruns; used for loopback tests and host-to-FPGA commands.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), cycles from start-edge detection to start-bit sample.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  8  received byte, LSB is the first data bit on the line.
- data_valid  out  1  data_out holds an unconsumed byte.
- data_ready  in  1  consumer accepts data_out this cycle when data_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the holding register was full and not being drained.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset is clock: clk; reset: rst, synchronous, active-high.
- Reset values: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, both synchroniser flops=1.
- rx is the only asynchronous input. It passes through a 2-flop synchroniser to give rx_s, adding 2 cycles of latency. All decisions use rx_s.
- Bit counter cnt and bit index idx[2:0] are internal. cnt is cleared on every state entry and after every sample.
- FSM states and transitions:
  - IDLE: when rx_s=0, go to START; cnt=0.
  - START: sample rx_s when HALF_BIT cycles have elapsed since entry.
    - Sample = 0: go to DATA, idx=0.
    - Sample = 1: glitch; go to IDLE with no flags raised.
  - DATA: sample every CLKS_PER_BIT cycles. Shift the sample into a shift register LSB-first (bit idx). After idx=7 is sampled, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample = 1: byte complete; go to IDLE. The next start is detectable the following cycle.
    - Sample = 0: frame_err pulses 1 cycle; the byte is discarded; go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err and no further bytes.
- Sample times, relative to the cycle t in which IDLE sees rx_s=0:
  - start bit at t+HALF_BIT;
  - data bit k at t+HALF_BIT+(k+1)*CLKS_PER_BIT;
  - stop bit at t+HALF_BIT+9*CLKS_PER_BIT.
- Output handshake:
  - A transfer occurs when data_valid & data_ready; data_valid then falls the next cycle unless a new byte loads in the same cycle.
  - On byte complete with data_valid=0, or with data_valid=1 & data_ready=1: data_out<=byte and data_valid<=1 in the cycle after the stop sample.
  - On byte complete with data_valid=1 & data_ready=0: new byte dropped, data_out unchanged, overrun pulses 1 cycle.
  - data_out is stable while data_valid=1 and not yet accepted.
- busy = (state != IDLE), registered with the state.
- rst mid-frame: immediate return to IDLE, holding register cleared, no flags. A frame in progress is lost. A low rx after reset starts a new detection, which is permitted.
- Width rule: cnt is $clog2(CLKS_PER_BIT) bits wide; the compare constants are sized to cnt.

Decomposition:
- Shared package uart_pkg:
  - localparam for the default CLKS_PER_BIT (868), shared with the transmitter;
  - rx state enum {IDLE, START, DATA, STOP, BREAK};
  - DATA_BITS=8.
- One natural sub-module: sync_2ff, a generic 1-bit 2-flop synchroniser with a reset value parameter, reusable elsewhere.

Test Plan (CLKS_PER_BIT=16, bench-driven ideal UART source):
- Send 0x42 with data_ready=1 held -> data_valid pulses 1 cycle with data_out=0x42; frame_err=0, overrun=0; valid asserts 2+8+9*16+1 cycles after the rx falling edge.
- Send 0x55 then 0xA3 back-to-back with data_ready=0 -> data_out=0x55 and valid held; overrun pulses once at the end of 0xA3. Then raise data_ready -> 0x55 is accepted and valid drops the next cycle.
- Send 0x00, 0xFF and 0x80 with ready=1 -> the three bytes are received in order with no flags.
- rx low for 5 cycles (shorter than 8) then high -> busy asserts, FSM returns to IDLE, no valid, no frame_err.
- Send 0x3C with the stop bit forced 0, then hold rx low for 40 cycles before releasing -> exactly one frame_err pulse, no data_valid. A following 0x3C is received correctly.
- Assert rst for 1 cycle mid-way through data bit 4 of 0x99 -> all outputs return to 0 and busy=0. The next full frame 0x99 is received correctly.
